// File: rtl/decoder_sel_sequencer.sv
// Select-index sequencer for decoder_3to8.
// Steps sel_out through 0..2^SEL_W-1. Each index is held for dwell+1 cycles.
// The sweep either wraps for ever or makes one pass and then pulses done.
// start/stop are sampled at each edge. mode and dwell are latched when a sweep starts.
module decoder_sel_sequencer #(
  parameter int unsigned SEL_W   = 3,
  parameter int unsigned DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic [DWELL_W-1:0] dwell,
  output logic [SEL_W-1:0]   sel_out,
  output logic               active,
  output logic               step,
  output logic               done
);

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } state_e;

  // Last index of a sweep; after it we either wrap or finish.
  localparam logic [SEL_W-1:0] SelMax = '1;

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               mode_q, mode_d;
  logic               active_q, active_d;
  logic               step_q, step_d;
  logic               done_q, done_d;

  // Next-state and registered-output decode; pulses default low every cycle.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    dwell_d  = dwell_q;
    mode_d   = mode_q;
    active_d = active_q;
    step_d   = 1'b0;
    done_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        sel_d    = '0;
        cnt_d    = '0;
        active_d = 1'b0;
        // stop has priority, so start+stop together keeps us idle.
        if (start && !stop) begin
          state_d  = StRun;
          active_d = 1'b1;
          dwell_d  = dwell;
          mode_d   = mode;
        end
      end

      StRun: begin
        if (stop) begin
          state_d  = StIdle;
          sel_d    = '0;
          cnt_d    = '0;
          active_d = 1'b0;
        end else if (cnt_q != dwell_q) begin
          cnt_d = cnt_q + DWELL_W'(1);
        end else begin
          cnt_d = '0;
          if (sel_q != SelMax) begin
            sel_d  = sel_q + SEL_W'(1);
            step_d = 1'b1;
          end else if (!mode_q) begin
            sel_d  = '0;
            step_d = 1'b1;
          end else begin
            // Single pass complete: done coincides with the drop of active.
            state_d  = StIdle;
            sel_d    = '0;
            active_d = 1'b0;
            done_d   = 1'b1;
          end
        end
      end

      default: begin
        state_d  = StIdle;
        sel_d    = '0;
        cnt_d    = '0;
        active_d = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      sel_q    <= '0;
      cnt_q    <= '0;
      dwell_q  <= '0;
      mode_q   <= 1'b0;
      active_q <= 1'b0;
      step_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      dwell_q  <= dwell_d;
      mode_q   <= mode_d;
      active_q <= active_d;
      step_q   <= step_d;
      done_q   <= done_d;
    end
  end

  assign sel_out = sel_q;
  assign active  = active_q;
  assign step    = step_q;
  assign done    = done_q;

endmodule

// File: tb/tb_decoder_sel_sequencer.sv
// Self-checking bench for decoder_sel_sequencer.
// A cycle model pushes the expected outputs into a queue.
// Each DUT output is popped and compared after the clock edge.
// A small vector table also carries hand-written expectations.
module tb_decoder_sel_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic       mode;
  logic [7:0] dwell;
  logic [2:0] sel_out;
  logic       active;
  logic       step;
  logic       done;

  decoder_sel_sequencer #(
    .SEL_W  (3),
    .DWELL_W(8)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .stop   (stop),
    .mode   (mode),
    .dwell  (dwell),
    .sel_out(sel_out),
    .active (active),
    .step   (step),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] sel;
    logic       act;
    logic       stp;
    logic       dn;
  } exp_t;

  typedef struct {
    logic       s;
    logic       p;
    logic       m;
    logic [7:0] d;
    logic [2:0] sel;
    logic       act;
    logic       stp;
    logic       dn;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[7];

  int n_cmp = 0;
  int n_err = 0;

  // Model state: position counts the cycles elapsed since the sweep was started.
  bit m_run  = 1'b0;
  bit m_mode = 1'b0;
  int m_p    = 0;
  int m_d    = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic s, input logic p, input logic m, input logic [7:0] d);
    exp_t e;
    e.sel = 3'd0;
    e.act = 1'b0;
    e.stp = 1'b0;
    e.dn  = 1'b0;
    if (!m_run) begin
      if (s && !p) begin
        m_run  = 1'b1;
        m_p    = 0;
        m_d    = int'(d);
        m_mode = m;
        e.act  = 1'b1;
      end
    end else if (p) begin
      m_run = 1'b0;
    end else begin
      m_p++;
      if (m_mode && m_p == 8 * (m_d + 1)) begin
        m_run = 1'b0;
        e.dn  = 1'b1;
      end else begin
        e.act = 1'b1;
        e.sel = 3'((m_p / (m_d + 1)) % 8);
        e.stp = ((m_p % (m_d + 1)) == 0);
      end
    end
    sb_q.push_back(e);
  endtask

  task automatic check_out(input string nm);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: scoreboard empty, got sel=%0d", nm, sel_out);
    end else begin
      e = sb_q.pop_front();
      chk({nm, ".sel"}, int'(sel_out), int'(e.sel));
      chk({nm, ".active"}, int'(active), int'(e.act));
      chk({nm, ".step"}, int'(step), int'(e.stp));
      chk({nm, ".done"}, int'(done), int'(e.dn));
      chk({nm, ".onehot"}, int'(8'b1 << sel_out), int'(8'b1 << e.sel));
    end
  endtask

  task automatic tick(input logic s, input logic p, input logic m, input logic [7:0] d,
                      input string nm);
    @(negedge clk);
    start = s;
    stop  = p;
    mode  = m;
    dwell = d;
    model_step(s, p, m, d);
    @(posedge clk);
    #1;
    check_out(nm);
  endtask

  initial begin : main
    int nsteps;
    int done_at;

    // Columns: start, stop, mode, dwell -> sel_out, active, step, done.
    vecs[0] = '{1'b0, 1'b0, 1'b0, 8'd0, 3'd0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 8'd0, 3'd0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 8'd0, 3'd0, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 8'd5, 3'd1, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 8'd5, 3'd2, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 8'd0, 3'd0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 8'd0, 3'd0, 1'b0, 1'b0, 1'b0};

    rst   = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    mode  = 1'b0;
    dwell = 8'd0;
    repeat (2) @(negedge clk);
    chk("reset.sel", int'(sel_out), 0);
    chk("reset.active", int'(active), 0);
    chk("reset.step", int'(step), 0);
    chk("reset.done", int'(done), 0);
    rst = 1'b0;

    // Vector table: start+stop in idle, a short sweep with D=0, then a stop.
    for (int i = 0; i < 7; i++) begin
      tick(vecs[i].s, vecs[i].p, vecs[i].m, vecs[i].d, "vec");
      chk("vec_tab.sel", int'(sel_out), int'(vecs[i].sel));
      chk("vec_tab.active", int'(active), int'(vecs[i].act));
      chk("vec_tab.step", int'(step), int'(vecs[i].stp));
      chk("vec_tab.done", int'(done), int'(vecs[i].dn));
    end

    // Single pass, D=2: 7 steps, and done on the 24th edge after start.
    tick(1'b1, 1'b0, 1'b1, 8'd2, "pass_start");
    nsteps  = 0;
    done_at = -1;
    for (int i = 1; i <= 26; i++) begin
      tick(1'b0, 1'b0, 1'b0, 8'd0, "pass");
      if (step) nsteps++;
      if (done) done_at = i;
    end
    chk("pass_steps", nsteps, 7);
    chk("pass_done_cycle", done_at, 24);

    // Free run, D=0, over 20 cycles; done must stay low.
    tick(1'b1, 1'b0, 1'b0, 8'd0, "free_start");
    for (int i = 0; i < 20; i++) tick(1'b0, 1'b0, 1'b0, 8'd0, "free");
    tick(1'b0, 1'b1, 1'b0, 8'd0, "free_stop");

    // Stop at sel=3 while cnt=2 with D=4.
    tick(1'b1, 1'b0, 1'b0, 8'd4, "stopmid_start");
    for (int i = 0; i < 17; i++) tick(1'b0, 1'b0, 1'b0, 8'd4, "stopmid_run");
    chk("stopmid_pre_sel", int'(sel_out), 3);
    tick(1'b0, 1'b1, 1'b0, 8'd4, "stopmid_stop");
    tick(1'b1, 1'b1, 1'b0, 8'd4, "startstop_idle");

    // Latching: mode and dwell change mid-run, and a start pulse arrives during RUN.
    tick(1'b1, 1'b0, 1'b1, 8'd1, "latch_start");
    done_at = -1;
    for (int i = 1; i <= 18; i++) begin
      tick((i == 3), 1'b0, 1'b0, 8'd9, "latch");
      if (done) done_at = i;
    end
    chk("latch_done_cycle", done_at, 16);

    // Back-to-back: start held high with D=0 and single pass.
    done_at = -1;
    for (int i = 0; i < 12; i++) begin
      tick(1'b1, 1'b0, 1'b1, 8'd0, "b2b");
      if (done && done_at < 0) done_at = i;
    end
    chk("b2b_done_cycle", done_at, 8);
    tick(1'b0, 1'b1, 1'b0, 8'd0, "b2b_stop");

    // Maximum dwell: D=255 holds each index for 256 cycles.
    tick(1'b1, 1'b0, 1'b0, 8'd255, "dmax_start");
    for (int i = 0; i < 258; i++) tick(1'b0, 1'b0, 1'b0, 8'd0, "dmax");
    chk("dmax_sel", int'(sel_out), 1);
    tick(1'b0, 1'b1, 1'b0, 8'd0, "dmax_stop");

    // Asynchronous reset mid-sweep at sel=5.
    tick(1'b1, 1'b0, 1'b0, 8'd3, "arst_start");
    for (int i = 0; i < 20; i++) tick(1'b0, 1'b0, 1'b0, 8'd3, "arst_run");
    chk("arst_pre_sel", int'(sel_out), 5);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst.sel", int'(sel_out), 0);
    chk("arst.active", int'(active), 0);
    chk("arst.step", int'(step), 0);
    chk("arst.done", int'(done), 0);
    m_run = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0, 8'd0, "arst_after");

    chk("sb_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/decoder_sel_sequencer.md
Name: decoder_sel_sequencer

Overview:
- Upstream driver for decoder_3to8: steps a 3-bit select index 0..7 at a programmable dwell rate and presents it on sel_out, which connects directly to the decoder's "in" port.
- Replaces hand-timed select stepping with a clocked, start/stop-controlled sequencer, for LED/digit scanning and one-hot enable sweeps.
- Supports free-running (wrap) and single-pass modes, and emits step and done pulses for downstream bookkeeping.

Parameters:
- SEL_W, 3, width of the select index; the index counts 0..2^SEL_W-1.
- DWELL_W, 8, width of the dwell input and the internal dwell counter.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  level-sampled; begins a sweep when the block is idle.
- stop  input  1  level-sampled; aborts a sweep and returns to idle.
- mode  input  1  0 = free-run with wrap 7->0; 1 = single pass 0..7 then stop. Latched at start.
- dwell  input  DWELL_W  D; each index is held for D+1 cycles. Latched at start.
- sel_out  output  SEL_W  registered select index to decoder_3to8.
- active  output  1  high while in RUN.
- step  output  1  one-cycle pulse, coincident with each new sel_out value after the first.
- done  output  1  one-cycle pulse when a single-pass sweep completes.

Behaviour:
- Reset (async, rst=1): state=IDLE; sel_out=0, active=0, step=0, done=0; dwell counter=0; latched mode=0; latched dwell=0. Outputs change immediately on rst assertion, without waiting for a clock edge.
- Two states: IDLE and RUN. All outputs are registered.
- IDLE:
  - sel_out=0, active=0.
  - If start=1 and stop=0 at an edge: next state=RUN, sel_out=0, cnt=0, active=1, mode and dwell latched.
  - If start and stop are both 1, stop wins and the block stays in IDLE.
- RUN, at each edge:
  - If stop=1: go to IDLE; sel_out=0, cnt=0, active=0, no step/done pulse.
  - Else if cnt != D_lat: cnt increments.
  - Else (cnt == D_lat): cnt<=0, then:
    - sel_out<7: sel_out increments, step=1 for one cycle.
    - sel_out==7, mode_lat=0: sel_out wraps to 0, step=1.
    - sel_out==7, mode_lat=1: go to IDLE; sel_out=0, active=0, done=1 for one cycle, step=0.
- Timing:
  - Each index is visible for exactly D_lat+1 cycles.
  - A single pass lasts 8*(D_lat+1) cycles from the first cycle active=1 to the cycle done=1 (done coincides with active=0).
  - D=0 gives a new index every cycle.
- Edge rules:
  - start while in RUN is ignored.
  - Changes to dwell or mode during RUN are ignored until the next start.
  - start held high through completion of a single pass restarts the sweep on the edge after done (IDLE samples start=1). That IDLE cycle shows sel_out=0, active=0.
  - The dwell counter and D compare are unsigned DWELL_W; D=2^DWELL_W-1 is legal (256-cycle dwell at default width).
- Reset mid-sweep forces all of the IDLE/reset values asynchronously. No pulse is emitted on reset release.
- sel_out never takes a value outside 0..7, so decoder_3to8 output is always exactly one-hot.

Test Plan:
- Reset: assert rst mid-sweep at sel_out=5 -> sel_out=0, active=0, step=0, done=0 immediately, before the next clk edge. After release with start=0, outputs stay at 0.
- Single pass, D=2, mode=1, start pulsed 1 cycle -> sel_out 0,1,...,7, each held 3 cycles. step pulses 7 times. done=1 on cycle 24 after start is sampled, with active=0 and sel_out=0 on that same cycle. Decoder out = 8'h01,8'h02,...,8'h80 in order.
- Free run, D=0, mode=0 -> sel_out changes every cycle 0..7,0,1,... step high every cycle after the first. done never asserts over 20 cycles.
- Stop at sel_out=3 mid-dwell (D=4, cnt=2) -> next edge: sel_out=0, active=0, no step/done. start and stop together in IDLE -> remains IDLE.
- Latching: start with D=1, mode=1, then change dwell to 9 and mode to 0 during RUN -> each index is still held 2 cycles and done fires after 16 cycles. A start pulse during RUN has no effect.
- Back-to-back: start held high with D=0, mode=1 -> done after 8 cycles, one IDLE cycle (sel_out=0, active=0), then a new sweep begins with active=1.
